mac_dot_engine: RTL and testbench
=================================

MAC_DOT_ENGINE -- requirements
Module: mac_dot_engine

Interface
REQ-001 SHALL expose port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-002 SHALL expose port rst, input, 1, reset, asynchronous, active-high.
REQ-003 SHALL expose port in_valid, input, 1, operand beat valid.
REQ-004 SHALL expose port in_ready, output, 1, engine accepts beat; a beat transfers when in_valid and in_ready are high at the same edge.
REQ-005 SHALL expose ports in_a and in_b, input, 16 each, signed two's-complement operands.
REQ-006 SHALL expose port in_bias, input, 16, signed addend, sampled only on the first beat of a vector.
REQ-007 SHALL expose port in_last, input, 1, marks the final beat of a vector.
REQ-008 SHALL expose port out_valid, output, 1, result available.
REQ-009 SHALL expose port out_ready, input, 1, consumer accepts the result; a transfer occurs when out_valid and out_ready are high at the same edge.
REQ-010 SHALL expose port out_data, output, 32, signed saturated result.
REQ-011 SHALL expose port out_ovf, output, 1, high when out_data was clamped.
REQ-012 SHALL expose port out_count, output, 16, number of beats in the vector (wraps modulo 2^16).

Function
REQ-013 SHALL compute out_data = sat32(sign-extended bias + sum of in_a*in_b over all beats of the vector), using signed 32-bit products.
REQ-014 SHALL accumulate in a 48-bit signed register and saturate only at output: above 0x7FFFFFFF gives 0x7FFFFFFF, below 0x80000000 gives 0x80000000; out_ovf=1 whenever a clamp occurs.
REQ-015 SHALL use states IDLE, ACCUM, DRAIN and HOLD.
REQ-016 IDLE: in_ready=1; an accepted beat loads the accumulator with the sign-extended bias, starts the product and goes to ACCUM, or to DRAIN if in_last is set.
REQ-017 ACCUM: in_ready=1; each accepted beat adds its product; in_last goes to DRAIN; with no in_valid the state is held and nothing is added.
REQ-018 The product SHALL be registered one cycle (mult stage), then added to the accumulator the following cycle; back-to-back beats SHALL sustain one beat per cycle.
REQ-019 DRAIN: in_ready=0; after the last product is added, out_data, out_ovf and out_count are registered and out_valid=1 in HOLD.
REQ-020 out_valid SHALL rise exactly 3 cycles after the edge that accepts the in_last beat.
REQ-021 HOLD: in_ready=0; out_data, out_ovf and out_count stay stable until transfer; on transfer, out_valid clears the same edge and the state returns to IDLE.
REQ-022 A single-beat vector (in_last on the first beat) SHALL be legal and yield bias + a*b.
REQ-023 The product SHALL be exact for -32768*-32768 = 0x40000000.
REQ-024 out_count SHALL equal the number of accepted beats modulo 65536; the 48-bit accumulator is exact up to 65536 beats.
REQ-025 in_a, in_b, in_bias and in_last SHALL be ignored when no beat transfers.

Reset
REQ-026 rst high SHALL immediately force state IDLE, in_ready=0, out_valid=0, out_data=0, out_ovf=0, out_count=0, and clear the accumulator and mult stage.
REQ-027 in_ready SHALL go to 1 on the first clk edge after rst is released.
REQ-028 Reset mid-vector or mid-HOLD SHALL discard the partial result with no output transfer.

Structure
REQ-029 Shared package mac_pkg SHALL hold the state enum, the operand, product and accumulator widths (16/32/48), and the SAT_MAX and SAT_MIN constants.
REQ-030 Sub-module mac_mult_reg SHALL contain the registered signed 16x16 multiply, mappable to a MAC16 DSP with registered output; control and accumulation stay in mac_dot_engine.

Verification
REQ-031 Single beat a=5, b=3, bias=10 -> out_data=25, out_ovf=0, out_count=1, out_valid 3 cycles after accept.
REQ-032 Beats (-2,7,bias=0),(3,4,last) -> out_data=-2 (0xFFFFFFFE), out_count=2.
REQ-033 Three beats of 32767*32767, bias=0 -> out_data=0x7FFFFFFF, out_ovf=1; three beats of -32768*32767 -> out_data=0x80000000, out_ovf=1.
REQ-034 out_ready held low for 10 cycles in HOLD -> out_data stable, in_ready=0 throughout; single transfer when released, then IDLE.
REQ-035 rst asserted after 2 beats of a 4-beat vector, then a fresh vector 1*1, bias=0 -> out_data=1, out_count=1, no stale output.

Source files
------------

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared widths, FSM states and saturation helper for the dot-product MAC
package mac_pkg;

    localparam int OP_W   = 16;
    localparam int PROD_W = 32;
    localparam int ACC_W  = 48;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 48'sh0000_7FFF_FFFF;
    localparam logic signed [ACC_W-1:0] SAT_MIN = 48'shFFFF_8000_0000;

    // Returns {clamped, value[31:0]} for a 48-bit accumulator.
    function automatic logic [PROD_W:0] sat_acc(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) begin
            return {1'b1, SAT_MAX[PROD_W-1:0]};
        end else if (v < SAT_MIN) begin
            return {1'b1, SAT_MIN[PROD_W-1:0]};
        end else begin
            return {1'b0, v[PROD_W-1:0]};
        end
    endfunction

endpackage

// File: rtl/mac_mult_reg.sv
// rtl/mac_mult_reg.sv - registered signed 16x16 multiply (DSP-mappable)
// Ports: clk, rst (async, active-high); en loads a*b into p; p_valid marks
// that p was loaded on the previous edge.
module mac_mult_reg
    import mac_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic signed [OP_W-1:0]   a,
    input  logic signed [OP_W-1:0]   b,
    output logic signed [PROD_W-1:0] p,
    output logic                     p_valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p       <= '0;
            p_valid <= 1'b0;
        end else begin
            p_valid <= en;
            if (en) begin
                p <= PROD_W'(a) * PROD_W'(b);
            end
        end
    end

endmodule

// File: rtl/mac_dot_engine.sv
// rtl/mac_dot_engine.sv - streaming signed dot-product engine with bias and 32-bit saturation
// Ports: clk, rst (async, active-high); input beats in_valid/in_ready with
// in_a, in_b, in_bias (first beat only), in_last; result out_valid/out_ready
// with out_data (saturated), out_ovf (clamped) and out_count (beats mod 2^16).
module mac_dot_engine
    import mac_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OP_W-1:0]       in_a,
    input  logic [OP_W-1:0]       in_b,
    input  logic [OP_W-1:0]       in_bias,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PROD_W-1:0]     out_data,
    output logic                  out_ovf,
    output logic [15:0]           out_count
);

    state_t                    state;
    logic                      rdy_q;
    logic signed [ACC_W-1:0]   acc;
    logic [15:0]               cnt;
    logic [1:0]                dcnt;
    logic [PROD_W:0]           sat_q;
    logic signed [PROD_W-1:0]  prod;
    logic                      prod_valid;
    logic                      accept;

    // rdy_q keeps in_ready low while reset is held and for the cycle up to
    // the first edge after release.
    assign in_ready = rdy_q && (state == IDLE || state == ACCUM);
    assign accept   = in_valid && in_ready;

    mac_mult_reg u_mult (
        .clk     (clk),
        .rst     (rst),
        .en      (accept),
        .a       (in_a),
        .b       (in_b),
        .p       (prod),
        .p_valid (prod_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rdy_q     <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            dcnt      <= '0;
            sat_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_count <= '0;
        end else begin
            rdy_q <= 1'b1;
            // Free-running saturation stage; only its value after the last
            // product has landed is ever copied to the outputs.
            sat_q <= sat_acc(acc);

            // No product is in flight in IDLE, so the bias load never
            // competes with an add.
            if (accept && state == IDLE) begin
                acc <= {{(ACC_W-OP_W){in_bias[OP_W-1]}}, in_bias};
            end else if (prod_valid) begin
                acc <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt   <= 16'd1;
                        dcnt  <= '0;
                        state <= in_last ? DRAIN : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        cnt <= cnt + 16'd1;
                        if (in_last) begin
                            dcnt  <= '0;
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Edge 1 adds the last product, edge 2 saturates it,
                    // edge 3 publishes the result.
                    if (dcnt == 2'd2) begin
                        out_data  <= sat_q[PROD_W-1:0];
                        out_ovf   <= sat_q[PROD_W];
                        out_count <= cnt;
                        out_valid <= 1'b1;
                        dcnt      <= '0;
                        state     <= HOLD;
                    end else begin
                        dcnt <= dcnt + 2'd1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_dot_engine.sv
// tb/tb_mac_dot_engine.sv - self-checking bench for mac_dot_engine
module tb_mac_dot_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [15:0] in_bias;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_ovf;
    logic [15:0] out_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mac_dot_engine dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_bias   (in_bias),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_count (out_count)
    );

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send_beat(input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] bias, input logic last);
        int guard = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_bias = bias; in_last = last;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (guard >= 50) begin
            n_bad++;
            $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, guard);
        end
        @(negedge clk);
        // Idle inputs carry junk that must be ignored.
        in_valid = 1'b0;
        in_a = 16'($urandom); in_b = 16'($urandom); in_bias = 16'($urandom);
        in_last = 1'($urandom);
    endtask

    task automatic get_result(input string tag, input logic [31:0] ed, input logic eo,
                              input logic [15:0] ec, input int exp_lat, input int hold);
        int cyc = 0;
        logic stable = 1'b1;
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (!out_valid) begin
            n_bad++;
            $display("FAIL %s_out_valid_timeout: out_valid=0 after %0d cycles, required 1", tag, cyc);
            return;
        end
        if (exp_lat >= 0) begin
            n_cmp++;
            if (cyc !== exp_lat) begin
                n_bad++;
                $display("FAIL %s_latency: got %0d cycles, required %0d", tag, cyc, exp_lat);
            end
        end
        n_cmp++;
        if (out_data !== ed || out_ovf !== eo || out_count !== ec) begin
            n_bad++;
            $display("FAIL %s_result: got data=%h ovf=%0b count=%0d, required data=%h ovf=%0b count=%0d",
                     tag, out_data, out_ovf, out_count, ed, eo, ec);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== ed ||
                out_ovf !== eo || out_count !== ec) stable = 1'b0;
        end
        if (hold > 0) begin
            n_cmp++;
            if (!stable) begin
                n_bad++;
                $display("FAIL %s_hold_stable: outputs changed or in_ready high during hold, required stable (data=%h)", tag, ed);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_after_transfer: out_valid=%0b in_ready=%0b, required 0 and 1", tag, out_valid, in_ready);
        end
    endtask

    // Reference: bias + sum of products in wide arithmetic, clamped to 32 bits.
    task automatic run_vec(input string tag, input int n, input logic [15:0] av[8],
                           input logic [15:0] bv[8], input logic [15:0] bias,
                           input int gaps, input int hold);
        longint      s;
        logic [31:0] ed;
        logic        eo;
        s = longint'($signed(bias));
        for (int i = 0; i < n; i++) begin
            s += longint'($signed(av[i])) * longint'($signed(bv[i]));
            send_beat(av[i], bv[i], (i == 0) ? bias : 16'($urandom), i == n - 1);
            if (gaps > 0 && i < n - 1) repeat ($urandom_range(0, gaps)) @(negedge clk);
        end
        if (s > 64'sd2147483647) begin
            ed = 32'h7FFF_FFFF; eo = 1'b1;
        end else if (s < -64'sd2147483648) begin
            ed = 32'h8000_0000; eo = 1'b1;
        end else begin
            ed = 32'(s); eo = 1'b0;
        end
        get_result(tag, ed, eo, 16'(n), 3, hold);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_bias = '0; in_last = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'd0 ||
            out_ovf !== 1'b0 || out_count !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_state: in_ready=%0b out_valid=%0b data=%h ovf=%0b count=%0d, required all 0",
                     in_ready, out_valid, out_data, out_ovf, out_count);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release_early: in_ready=%0b, required 0", in_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready: in_ready=%0b, required 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [15:0] av[8];
        logic [15:0] bv[8];
        av = '{default: 16'd0}; bv = '{default: 16'd0};
        av[0] = 16'd5; bv[0] = 16'd3;
        run_vec("single", 1, av, bv, 16'd10, 0, 0);
        av[0] = 16'hFFFE; bv[0] = 16'd7; av[1] = 16'd3; bv[1] = 16'd4;
        run_vec("two_beat", 2, av, bv, 16'd0, 0, 0);
        av[0] = 16'h8000; bv[0] = 16'h8000;
        run_vec("min_sq", 1, av, bv, 16'd0, 0, 0);
    endtask

    task automatic test_saturation();
        logic [15:0] av[8];
        logic [15:0] bv[8];
        av = '{default: 16'h7FFF}; bv = '{default: 16'h7FFF};
        run_vec("sat_pos", 3, av, bv, 16'd0, 0, 0);
        av = '{default: 16'h8000};
        run_vec("sat_neg", 3, av, bv, 16'd0, 0, 0);
    endtask

    task automatic test_hold();
        logic [15:0] av[8];
        logic [15:0] bv[8];
        av = '{default: 16'd0}; bv = '{default: 16'd0};
        av[0] = 16'd100; bv[0] = 16'hFF9C; av[1] = 16'd7; bv[1] = 16'd9;
        run_vec("hold", 2, av, bv, 16'h1234, 1, 10);
    endtask

    task automatic test_reset_mid();
        logic [15:0] av[8];
        logic [15:0] bv[8];
        send_beat(16'd9, 16'd9, 16'd50, 1'b0);
        send_beat(16'd9, 16'd9, 16'd50, 1'b0);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_vector: in_ready=%0b out_valid=%0b, required 0 and 0", in_ready, out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        av = '{default: 16'd1}; bv = '{default: 16'd1};
        run_vec("after_reset", 1, av, bv, 16'd0, 0, 0);
        // Reset while a result is held.
        send_beat(16'd2, 16'd2, 16'd0, 1'b1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 32'd0 || out_count !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_mid_hold: out_valid=%0b data=%h count=%0d, required 0", out_valid, out_data, out_count);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [15:0] av[8];
        logic [15:0] bv[8];
        logic [15:0] bias;
        int          n;
        for (int v = 0; v < 25; v++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < 8; i++) begin
                case ($urandom_range(0, 3))
                    0:       begin av[i] = 16'h7FFF; bv[i] = 16'h7FFF; end
                    1:       begin av[i] = 16'h8000; bv[i] = 16'(($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000); end
                    default: begin av[i] = 16'($urandom); bv[i] = 16'($urandom); end
                endcase
            end
            bias = 16'($urandom);
            run_vec("random", n, av, bv, bias, (v % 2 == 0) ? 0 : 2, $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_saturation();
        test_hold();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
